// File: rtl/multicycle_cpu_ctrl_if.sv
// Shared memory port between the multi-cycle controller (master) and memory (slave).
// Carries the request/ready handshake plus the address-source select.
interface multicycle_cpu_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic addr_src;
    logic mem_ready;

    modport master (output mem_req, output mem_we, output addr_src, input mem_ready);
    modport slave  (input mem_req, input mem_we, input addr_src, output mem_ready);
endinterface

// File: rtl/multicycle_cpu_ctrl.sv
// Multi-cycle MIPS control sequencer sharing one memory port for fetch and data.
// Optional performance counters are enabled with `define PERF_CNT_EN.
module multicycle_cpu_ctrl #(
    parameter int unsigned W_CPU       = 32,
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned W_TMO       = 5
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    multicycle_cpu_ctrl_if.master   mem_bus,
    input  logic [5:0]              opcode_i,
    input  logic [5:0]              funct_i,
    input  logic                    is_zero_i,
    input  logic [W_CPU-1:0]        syscall_code_i,
    output logic                    ir_wen_o,
    output logic                    pc_wen_o,
    output logic [1:0]              pc_src_o,
    output logic                    reg_wen_o,
    output logic [1:0]              reg_dst_o,
    output logic [1:0]              reg_src_o,
    output logic                    alu_src_o,
    output logic [2:0]              alu_op_o,
    output logic                    halted_o,
    output logic [1:0]              err_o
`ifdef PERF_CNT_EN
    ,
    output logic [W_CPU-1:0]        cyc_cnt_o,
    output logic [W_CPU-1:0]        inst_cnt_o
`endif
);

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_e;

    localparam logic [W_TMO-1:0] TMO_LAST = W_TMO'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_e           state_q, state_d;
    logic [1:0]       err_q, err_d;
    logic [W_TMO-1:0] tmo_q, tmo_d;

    logic       req_c, we_c, asrc_c, ir_wen_c, pc_wen_c, reg_wen_c, alu_src_c, halted_c;
    logic [1:0] pc_src_c, reg_dst_c, reg_src_c;
    logic [2:0] alu_op_c;

    logic is_r, is_sys, is_jr, is_j, is_jal, is_beq, is_bne, is_addi, is_lw, is_sw, legal;
    logic alu_src_x, tmo_hit, sys_halt;
    logic [2:0] alu_op_x;

    assign is_r     = (opcode_i == 6'h00);
    assign is_sys   = is_r && (funct_i == 6'h0C);
    assign is_jr    = is_r && (funct_i == 6'h08);
    assign is_j     = (opcode_i == 6'h02);
    assign is_jal   = (opcode_i == 6'h03);
    assign is_beq   = (opcode_i == 6'h04);
    assign is_bne   = (opcode_i == 6'h05);
    assign is_addi  = (opcode_i == 6'h08);
    assign is_lw    = (opcode_i == 6'h23);
    assign is_sw    = (opcode_i == 6'h2B);
    assign legal    = is_r || is_j || is_jal || is_beq || is_bne || is_addi || is_lw || is_sw;
    assign sys_halt = (syscall_code_i == W_CPU'(10));

    // EXEC's ALU setup is re-driven in MEM and WB so the datapath sees stable controls.
    assign alu_src_x = is_addi || is_lw || is_sw;
    assign alu_op_x  = is_r ? 3'd7 : ((is_beq || is_bne) ? 3'd1 : 3'd0);

    // A ready in the cycle the count would reach MEM_TIMEOUT still counts as success.
    assign tmo_hit = (MEM_TIMEOUT != 0) && !mem_bus.mem_ready && (tmo_q == TMO_LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_FETCH;
            err_q   <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        err_d     = err_q;
        req_c     = 1'b0;
        we_c      = 1'b0;
        asrc_c    = 1'b0;
        ir_wen_c  = 1'b0;
        pc_wen_c  = 1'b0;
        pc_src_c  = '0;
        reg_wen_c = 1'b0;
        reg_dst_c = '0;
        reg_src_c = '0;
        alu_src_c = 1'b0;
        alu_op_c  = '0;
        halted_c  = 1'b0;
        case (state_q)
            S_FETCH: begin
                req_c = 1'b1;
                if (mem_bus.mem_ready) begin
                    ir_wen_c = 1'b1;
                    pc_wen_c = 1'b1;
                    state_d  = S_DECODE;
                end else if (tmo_hit) begin
                    state_d = S_HALT;
                    err_d   = 2'd2;
                end
            end
            S_DECODE: begin
                if (!legal) begin
                    state_d = S_HALT;
                    err_d   = 2'd1;
                end else if (is_sys) begin
                    state_d = sys_halt ? S_HALT : S_FETCH;
                end else if (is_j || is_jal || is_jr) begin
                    pc_wen_c = 1'b1;
                    pc_src_c = is_jr ? 2'd3 : 2'd2;
                    if (is_jal) begin
                        reg_wen_c = 1'b1;
                        reg_dst_c = 2'd2;
                        reg_src_c = 2'd2;
                    end
                    state_d = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_src_c = alu_src_x;
                alu_op_c  = alu_op_x;
                if (is_beq || is_bne) begin
                    pc_src_c = 2'd1;
                    pc_wen_c = is_beq ? is_zero_i : !is_zero_i;
                    state_d  = S_FETCH;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                req_c     = 1'b1;
                asrc_c    = 1'b1;
                we_c      = is_sw;
                alu_src_c = alu_src_x;
                alu_op_c  = alu_op_x;
                if (mem_bus.mem_ready) begin
                    state_d = is_sw ? S_FETCH : S_WB;
                end else if (tmo_hit) begin
                    state_d = S_HALT;
                    err_d   = 2'd2;
                end
            end
            S_WB: begin
                reg_wen_c = 1'b1;
                reg_dst_c = is_r ? 2'd1 : 2'd0;
                reg_src_c = is_lw ? 2'd1 : 2'd0;
                alu_src_c = alu_src_x;
                alu_op_c  = alu_op_x;
                state_d   = S_FETCH;
            end
            S_HALT: halted_c = 1'b1;
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        tmo_d = tmo_q;
        if (state_d != state_q)
            tmo_d = '0;
        else if (req_c && !mem_bus.mem_ready)
            tmo_d = tmo_q + 1'b1;
    end

    // Every output is forced low while reset is held, even though FETCH requests memory.
    assign mem_bus.mem_req  = rst_ni & req_c;
    assign mem_bus.mem_we   = rst_ni & we_c;
    assign mem_bus.addr_src = rst_ni & asrc_c;
    assign ir_wen_o   = rst_ni & ir_wen_c;
    assign pc_wen_o   = rst_ni & pc_wen_c;
    assign pc_src_o   = rst_ni ? pc_src_c : '0;
    assign reg_wen_o  = rst_ni & reg_wen_c;
    assign reg_dst_o  = rst_ni ? reg_dst_c : '0;
    assign reg_src_o  = rst_ni ? reg_src_c : '0;
    assign alu_src_o  = rst_ni & alu_src_c;
    assign alu_op_o   = rst_ni ? alu_op_c : '0;
    assign halted_o   = rst_ni & halted_c;
    assign err_o      = rst_ni ? err_q : '0;

`ifdef PERF_CNT_EN
    logic [W_CPU-1:0] cyc_q, inst_q;
    logic             retire;

    assign retire = ((state_d == S_FETCH) && (state_q != S_FETCH) && (state_q != S_HALT)) ||
                    ((state_q == S_DECODE) && (state_d == S_HALT) && is_sys);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cyc_q  <= '0;
            inst_q <= '0;
        end else if (state_q != S_HALT) begin
            cyc_q <= cyc_q + 1'b1;
            if (retire)
                inst_q <= inst_q + 1'b1;
        end
    end

    assign cyc_cnt_o  = cyc_q;
    assign inst_cnt_o = inst_q;
`endif

endmodule

// File: doc/multicycle_cpu_ctrl.md
Name: multicycle_cpu_ctrl

Overview:
Multi-cycle control sequencer for the MIPS datapath. It replaces the single-cycle combinational decode with a registered FSM that shares one memory port between instruction fetch and data access. It tolerates variable-latency memory through a req/ready handshake and halts on SYSCALL 10, an illegal opcode or a memory timeout. It sits between the IR/regfile/ALU datapath and the shared memory.

Parameters:
W_CPU, 32, datapath width; width of syscall_code and the perf counters
MEM_TIMEOUT, 16, maximum cycles to wait for mem_ready; 0 = wait forever
W_TMO, 5, width of the timeout counter; must satisfy 2^W_TMO > MEM_TIMEOUT

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  asynchronous, active-low reset
opcode  input  6  IR[31:26]
funct  input  6  IR[5:0]
is_zero  input  1  ALU zero flag
syscall_code  input  W_CPU  regfile read port 1 (v0) value
mem_ready  input  1  memory completes the current request this cycle
mem_req  output  1  memory request valid
mem_we  output  1  1 = write, 0 = read
addr_src  output  1  0 = PC, 1 = ALU result
ir_wen  output  1  latch IR from memory data
pc_wen  output  1  update PC
pc_src  output  2  0 = PC+4, 1 = branch target, 2 = jump target, 3 = register
reg_wen  output  1  regfile write enable
reg_dst  output  2  0 = rt, 1 = rd, 2 = $31
reg_src  output  2  0 = ALU, 1 = memory, 2 = PC
alu_src  output  1  0 = register, 1 = sign-extended immediate
alu_op  output  3  0 = add, 1 = sub, 2 = and, 3 = or, 4 = slt, 7 = funct-decoded
halted  output  1  FSM is in HALT
err  output  2  0 = none, 1 = illegal opcode, 2 = memory timeout

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, HALT. The state is registered; outputs are combinational from state, opcode, funct, is_zero and mem_ready.
- While rst=0: state = FETCH, err = 0, timeout counter = 0, and every output is forced to 0 regardless of state. Assertion mid-operation aborts the current instruction immediately, without completing its write.
- FETCH: mem_req=1, mem_we=0, addr_src=0. When mem_ready=1 in the same cycle: ir_wen=1, pc_wen=1, pc_src=0, next state DECODE. Otherwise the FSM stays in FETCH.
- DECODE (one cycle):
  - SYSCALL (op 0x00, funct 0x0C): if syscall_code==10 go to HALT, else go to FETCH.
  - J (0x02): pc_wen=1, pc_src=2, go to FETCH.
  - JAL (0x03): pc_wen=1, pc_src=2, reg_wen=1, reg_dst=2, reg_src=2, go to FETCH.
  - JR (op 0x00, funct 0x08): pc_wen=1, pc_src=3, go to FETCH.
  - Any other supported opcode goes to EXEC.
  - Unsupported opcode goes to HALT with err=1.
- Supported opcodes: 0x00, 0x02, 0x03, 0x04, 0x05, 0x08, 0x23, 0x2B.
- EXEC:
  - R-type: alu_src=0, alu_op=7, go to WB.
  - ADDI: alu_src=1, alu_op=0, go to WB.
  - LW/SW: alu_src=1, alu_op=0, go to MEM.
  - BEQ: alu_op=1; pc_wen=is_zero, pc_src=1; go to FETCH.
  - BNE: alu_op=1; pc_wen=!is_zero, pc_src=1; go to FETCH.
- MEM: mem_req=1, addr_src=1, mem_we=1 for SW and 0 for LW. On mem_ready, LW goes to WB and SW goes to FETCH.
- WB: reg_wen=1.
  - R-type: reg_dst=1, reg_src=0.
  - ADDI: reg_dst=0, reg_src=0.
  - LW: reg_dst=0, reg_src=1.
  - Next state FETCH.
- Data hold: the datapath holds the LW data and ALU result in registers between states. The controller re-drives alu_src/alu_op in MEM and WB identical to EXEC.
- Timeout:
  - The counter clears on entry to FETCH/MEM and increments on each cycle with mem_req=1 and mem_ready=0.
  - If MEM_TIMEOUT>0 and the counter reaches MEM_TIMEOUT with mem_ready still 0: go to HALT, err=2, mem_req drops the next cycle.
  - mem_ready in the same cycle the counter reaches MEM_TIMEOUT counts as success.
- HALT: all enables and mem_req are 0, halted=1, err is held. Only reset exits HALT.
- mem_ready outside FETCH/MEM is ignored.
- CPI without memory wait states: R/ADDI/LW = 4/4/5, SW = 4, branch = 3, jumps = 2.

Optional Feature:
PERF_CNT_EN.
- Defined: adds outputs cyc_cnt[W_CPU-1:0] and inst_cnt[W_CPU-1:0]. Both reset to 0.
  - cyc_cnt increments every cycle while not in HALT.
  - inst_cnt increments on every transition into FETCH from DECODE/EXEC/MEM/WB, and on the entry into HALT caused by SYSCALL 10.
  - Both counters wrap modulo 2^W_CPU and freeze in HALT.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
ADD (op 0, funct 0x20) with mem_ready tied 1 -> FETCH, DECODE, EXEC, WB, FETCH; reg_wen=1, reg_dst=1 in cycle 4; pc_wen only in cycle 1.
LW with mem_ready delayed 3 cycles in MEM -> mem_req=1, addr_src=1 for 4 cycles, then WB with reg_src=1; 8 cycles total.
BEQ with is_zero=1, then BNE with is_zero=1 -> BEQ: pc_wen=1, pc_src=1 in EXEC; BNE: pc_wen=0; each takes 3 cycles.
JAL 0x03 -> DECODE drives pc_src=2, reg_dst=2, reg_src=2, reg_wen=1; back in FETCH next cycle.
SYSCALL with syscall_code=10 -> halted=1 from the next cycle. Opcode 0x3F -> halted=1, err=1. mem_ready held 0 with MEM_TIMEOUT=16 -> HALT, err=2 after 16 request cycles.
rst driven low mid-MEM of an SW -> outputs 0 immediately; after release, state FETCH, err=0. With PERF_CNT_EN: cyc_cnt=0, inst_cnt=0.
